fetch_sequencer: RTL and testbench

Parametrised instruction-fetch control unit for the Mini SRC datapath. It generates, cycle by cycle, the T0–T2 fetch control signals (incPC, e_MAR, ram_read, MDR_read, e_MDR, e_IR, BusDataSelect) that the datapath otherwise needs from a bench or hand-written control. It adds three things: configurable RAM wait states, back-to-back fetch under a level `run`, and hold/abort controls. It sits beside the datapath and drives its control inputs directly.

---
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer.sv | 80 ++++++++
 tb/tb_fetch_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer and the Mini SRC datapath.
// The sequencer takes the master side and the datapath or bench takes the slave side.
interface fetch_sequencer_if #(
  parameter int SEL_W = 5,
  parameter int CNT_W = 16
);
  logic             run;
  logic             hold;
  logic             abort;
  logic             incPC;
  logic             e_MAR;
  logic             ram_read;
  logic             MDR_read;
  logic             e_MDR;
  logic             e_IR;
  logic [SEL_W-1:0] BusDataSelect;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  run, hold, abort,
    output incPC, e_MAR, ram_read, MDR_read, e_MDR, e_IR,
           BusDataSelect, busy, done, fetch_count
  );

  modport slave (
    output run, hold, abort,
    input  incPC, e_MAR, ram_read, MDR_read, e_MDR, e_IR,
           BusDataSelect, busy, done, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control unit: runs T0 (PC->MAR), T1 (RAM read plus wait states) and
// T2 (MDR->IR). It supports back-to-back fetch, hold and abort.
module fetch_sequencer #(
  parameter int               SEL_W   = 5,
  parameter logic [SEL_W-1:0] SEL_PC  = 5'b10100,
  parameter logic [SEL_W-1:0] SEL_MDR = 5'b10101,
  parameter int               RAM_LAT = 1,
  parameter int               CNT_W   = 16
) (
  input  logic              clock,
  input  logic              clear,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_T0, S_T1, S_T2} state_e;

  localparam logic [3:0] LAT = 4'(RAM_LAT);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Abort outranks hold. Hold also keeps IDLE from starting a fetch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    count_d = count_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      wait_d  = 4'd0;
    end else if (!bus.hold) begin
      case (state_q)
        S_IDLE: if (bus.run) state_d = S_T0;
        S_T0: begin
          state_d = S_T1;
          wait_d  = LAT;
        end
        S_T1: begin
          if (wait_q == 4'd0) state_d = S_T2;
          else                wait_d  = wait_q - 4'd1;
        end
        S_T2: begin
          count_d = count_q + 1'b1;
          state_d = bus.run ? S_T0 : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // Hold gates only the load and increment strobes. The read path and bus select stay up.
  logic in_t0, in_t1, in_t2;
  assign in_t0 = (state_q == S_T0);
  assign in_t1 = (state_q == S_T1);
  assign in_t2 = (state_q == S_T2);

  assign bus.incPC         = in_t0 & ~bus.hold;
  assign bus.e_MAR         = in_t0 & ~bus.hold;
  assign bus.ram_read      = in_t1;
  assign bus.MDR_read      = in_t1;
  assign bus.e_MDR         = in_t1 & (wait_q == 4'd0) & ~bus.hold;
  assign bus.e_IR          = in_t2 & ~bus.hold;
  assign bus.done          = in_t2 & ~bus.hold;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.fetch_count   = count_q;
  assign bus.BusDataSelect = in_t0 ? SEL_PC : (in_t2 ? SEL_MDR : '0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer. Three instances share one stimulus stream: A (RAM_LAT=1),
// B (RAM_LAT=0, CNT_W=2) and C (RAM_LAT=2). A phase-counting model checks each instance.
module tb_fetch_sequencer;

  logic clock = 1'b0;
  logic clear, run, hold, abort;
  always #5 clock = ~clock;

  fetch_sequencer_if #(.SEL_W(5), .CNT_W(16)) ifa ();
  fetch_sequencer_if #(.SEL_W(5), .CNT_W(2))  ifb ();
  fetch_sequencer_if #(.SEL_W(5), .CNT_W(16)) ifc ();

  assign ifa.run = run;  assign ifa.hold = hold;  assign ifa.abort = abort;
  assign ifb.run = run;  assign ifb.hold = hold;  assign ifb.abort = abort;
  assign ifc.run = run;  assign ifc.hold = hold;  assign ifc.abort = abort;

  fetch_sequencer #(.RAM_LAT(1), .CNT_W(16)) u_a (.clock(clock), .clear(clear), .bus(ifa));
  fetch_sequencer #(.RAM_LAT(0), .CNT_W(2))  u_b (.clock(clock), .clear(clear), .bus(ifb));
  fetch_sequencer #(.RAM_LAT(2), .CNT_W(16)) u_c (.clock(clock), .clear(clear), .bus(ifc));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: active flag, cycle index within the fetch, and completed-fetch count.
  int lat  [3] = '{1, 0, 2};
  int cmod [3] = '{65536, 4, 65536};
  bit m_act [3];
  int m_p   [3];
  int m_cnt [3];

  // Bit layout: busy done e_IR e_MDR MDR_read ram_read e_MAR incPC sel[4:0] count[15:0]
  function automatic logic [28:0] dut_word(int i);
    logic [28:0] w;
    case (i)
      0: w = {ifa.busy, ifa.done, ifa.e_IR, ifa.e_MDR, ifa.MDR_read, ifa.ram_read,
              ifa.e_MAR, ifa.incPC, ifa.BusDataSelect, ifa.fetch_count};
      1: w = {ifb.busy, ifb.done, ifb.e_IR, ifb.e_MDR, ifb.MDR_read, ifb.ram_read,
              ifb.e_MAR, ifb.incPC, ifb.BusDataSelect, 14'd0, ifb.fetch_count};
      default: w = {ifc.busy, ifc.done, ifc.e_IR, ifc.e_MDR, ifc.MDR_read, ifc.ram_read,
                    ifc.e_MAR, ifc.incPC, ifc.BusDataSelect, ifc.fetch_count};
    endcase
    return w;
  endfunction

  function automatic logic [28:0] exp_word(int i);
    logic [28:0] w;
    int p, l;
    w = '0;
    p = m_p[i];
    l = lat[i];
    w[15:0] = 16'(m_cnt[i]);
    if (m_act[i]) begin
      w[28] = 1'b1;
      if (p == 0) begin
        w[20:16] = 5'b10100;
        w[22]    = !hold;
        w[21]    = !hold;
      end else if (p <= l + 1) begin
        w[24] = 1'b1;
        w[23] = 1'b1;
        w[25] = (p == l + 1) && !hold;
      end else begin
        w[20:16] = 5'b10101;
        w[27]    = !hold;
        w[26]    = !hold;
      end
    end
    return w;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        m_act[i] = 0; m_p[i] = 0; m_cnt[i] = 0;
      end else if (abort) begin
        m_act[i] = 0;
      end else if (!m_act[i]) begin
        if (run && !hold) begin m_act[i] = 1; m_p[i] = 0; end
      end else if (!hold) begin
        if (m_p[i] == lat[i] + 2) begin
          m_cnt[i] = (m_cnt[i] + 1) % cmod[i];
          if (run) m_p[i] = 0;
          else     m_act[i] = 0;
        end else begin
          m_p[i] = m_p[i] + 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1; run = 0; hold = 0; abort = 0;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    clear = 1; run = 1; hold = 0; abort = 0;
    tick();
    run = 0;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dut_word(i) !== 29'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d got %h want 0", i, dut_word(i));
      end
    end
    clear = 0;
  endtask

  task automatic test_single_fetch();
    logic [6:0] ctl_t [5] = '{7'b0000011, 7'b0001100, 7'b0011100, 7'b1100000, 7'b0000000};
    logic [4:0] sel_t [5] = '{5'b10100, 5'b00000, 5'b00000, 5'b10101, 5'b00000};
    logic [28:0] w;
    do_clear();
    run = 1;
    tick();
    run = 0;
    for (int c = 0; c < 5; c++) begin
      #2;
      w = dut_word(0);
      n_checks++;
      if (w[27:21] !== ctl_t[c] || w[20:16] !== sel_t[c]) begin
        n_fail++;
        $display("FAIL single_fetch cycle %0d got ctl %b sel %b want ctl %b sel %b",
                 c, w[27:21], w[20:16], ctl_t[c], sel_t[c]);
      end
      tick();
    end
    n_checks++;
    if (ifa.fetch_count !== 16'd1 || ifa.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_fetch_count got %0d busy %b want 1 busy 0", ifa.fetch_count, ifa.busy);
    end
  endtask

  task automatic test_back_to_back();
    int incs = 0;
    do_clear();
    run = 1;
    tick();
    for (int c = 0; c < 9; c++) begin
      if (c == 8) run = 0;
      #2;
      if (ifb.incPC === 1'b1) incs++;
      n_checks++;
      if (ifb.done !== ((c % 3) == 2)) begin
        n_fail++;
        $display("FAIL b2b_done cycle %0d got %b want %b", c, ifb.done, (c % 3) == 2);
      end
      tick();
    end
    n_checks++;
    if (ifb.fetch_count !== 2'd3 || incs != 3 || ifb.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_summary got count %0d incPC %0d busy %b want 3 3 0",
               ifb.fetch_count, incs, ifb.busy);
    end
  endtask

  task automatic test_hold();
    int dones = 0;
    int done_at = -1;
    do_clear();
    run = 1;
    tick();
    run = 0;
    for (int c = 0; c < 12; c++) begin
      hold = (c >= 1 && c <= 4);
      #2;
      if (ifc.done === 1'b1) begin dones++; done_at = c; end
      if (hold) begin
        n_checks++;
        if (ifc.ram_read !== 1'b1 || ifc.e_MDR !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_read cycle %0d got ram_read %b e_MDR %b want 1 0",
                   c, ifc.ram_read, ifc.e_MDR);
        end
      end
      n_checks++;
      if (dut_word(2) !== exp_word(2)) begin
        n_fail++;
        $display("FAIL hold_model cycle %0d got %h want %h", c, dut_word(2), exp_word(2));
      end
      tick();
    end
    hold = 0;
    n_checks++;
    if (dones != 1 || done_at != 8 || ifc.fetch_count !== 16'd1) begin
      n_fail++;
      $display("FAIL hold_summary got dones %0d at %0d count %0d want 1 at 8 count 1",
               dones, done_at, ifc.fetch_count);
    end
  endtask

  task automatic test_abort();
    logic [28:0] w;
    do_clear();
    run = 1; tick(); run = 0;
    tick();
    abort = 1; tick(); abort = 0;
    #2;
    w = dut_word(0);
    n_checks++;
    if (w !== 29'd0) begin
      n_fail++;
      $display("FAIL abort_t1 got %h want 0", w);
    end
    run = 1; tick(); run = 0;
    for (int c = 0; c < 3; c++) tick();
    abort = 1; tick(); abort = 0;
    #2;
    w = dut_word(0);
    n_checks++;
    if (w !== 29'd0) begin
      n_fail++;
      $display("FAIL abort_t2 got %h want 0", w);
    end
    run = 1; tick(); run = 0;
    for (int c = 0; c < 5; c++) tick();
    n_checks++;
    if (ifa.fetch_count !== 16'd1 || ifa.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_recover got count %0d busy %b want 1 0", ifa.fetch_count, ifa.busy);
    end
  endtask

  task automatic test_clear_mid_fetch();
    run = 1; tick();
    clear = 1; abort = 1; hold = 1;
    tick();
    clear = 0; abort = 0; hold = 0; run = 0;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dut_word(i) !== 29'd0) begin
        n_fail++;
        $display("FAIL clear_mid dut%0d got %h want 0", i, dut_word(i));
      end
    end
  endtask

  task automatic test_counter_wrap();
    do_clear();
    run = 1;
    tick();
    for (int c = 0; c < 15; c++) begin
      if (c == 14) run = 0;
      #2;
      tick();
    end
    n_checks++;
    if (ifb.fetch_count !== 2'd1 || ifa.fetch_count !== 16'd3) begin
      n_fail++;
      $display("FAIL wrap got b=%0d a=%0d want b=1 a=3", ifb.fetch_count, ifa.fetch_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      clear = ($urandom_range(0, 63) == 0);
      abort = ($urandom_range(0, 15) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      run   = ($urandom_range(0, 1) == 1);
      #2;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (dut_word(i) !== exp_word(i)) begin
          n_fail++;
          $display("FAIL random cycle %0d dut%0d got %h want %h", c, i, dut_word(i), exp_word(i));
        end
      end
      tick();
    end
    clear = 0; abort = 0; hold = 0; run = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin m_act[i] = 0; m_p[i] = 0; m_cnt[i] = 0; end
    clear = 1; run = 0; hold = 0; abort = 0;
    tick();
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_hold();
    test_abort();
    test_clear_mid_fetch();
    test_counter_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
